hdmi_video_timing: RTL and testbench
====================================

// Module: hdmi_video_timing
// PURPOSE
//  Raster timing stage ahead of the per-lane TMDS encoders.
//  Free-running 720p60 counters drive x/y to the pixel/game generator.
//  Generator pixel comes back on pix_in with PIX_LAT cycles of latency.
//  Block delays de/hsync/vsync to match and emits aligned vid_* for the encoders.
//  Also produces frame_start and the game-speed tick (game_tick).
// PARAMETERS
//  HFRAME        1650  total clocks per line (hdmi_pkg)
//  HSCREEN       1280  visible clocks per line
//  HSYNC_START   1390  first hsync-active x
//  HSYNC_END     1430  first x after hsync
//  VFRAME        750   total lines per frame
//  VSCREEN       720   visible lines
//  VSYNC_START   725   first vsync-active line
//  VSYNC_END     730   first line after vsync
//  PIX_LAT       1     pix_in latency from x/y, range 1..4
//  MFRAM_CNT_MAX 30    frames per game_tick
// PORTS
//  clk          in   1   pixel clock (74.25 MHz), sole clock
//  arst_n       in   1   asynchronous reset, active low
//  x            out  12  current column, 0..HFRAME-1
//  y            out  12  current line, 0..VFRAME-1
//  frame_start  out  1   high while x==0 && y==0
//  game_tick    out  1   one-cycle pulse every MFRAM_CNT_MAX frames
//  pix_in       in   24  pix_t {R,G,B} for x/y issued PIX_LAT cycles earlier
//  vid_pix      out  24  aligned pixel to TMDS encoders
//  vid_de       out  1   aligned data enable
//  vid_hs       out  1   aligned hsync, HSYNC_POLARITY active
//  vid_vs       out  1   aligned vsync, VSYNC_POLARITY active
//  tpg_on       in   1   test pattern select; present only with HDMI_TPG_EN
// BEHAVIOUR
//  Clock and reset: one clock domain (clk); arst_n asynchronous, active low.
//  Reset values: x=0, y=0, mfram_cnt=0, all delay-line stages cleared.
//   Outputs in reset: vid_de=0, vid_pix=0, vid_hs=~HSYNC_POLARITY, vid_vs=~VSYNC_POLARITY.
//  Counters: x increments every clk.
//   At x==HFRAME-1: x->0 and y increments; y wraps VFRAME-1 -> 0 on that same edge.
//  Raw decode from registered x/y:
//   de  = x<HSCREEN && y<VSCREEN
//   hs  = HSYNC_POLARITY when HSYNC_START<=x<HSYNC_END, else inverted
//   vs  = VSYNC_POLARITY when VSYNC_START<=y<VSYNC_END, else inverted
//   vs changes at x==0, is line-aligned, and is held for 5 full lines.
//  Alignment: de/hs/vs pass through a PIX_LAT-deep shift register.
//   Stage 0 loads raw decode; stage PIX_LAT-1 drives vid_de/vid_hs/vid_vs.
//   vid_pix is combinational: pix_in when vid_de=1, else 24'h0 (black in blanking).
//   Net effect: vid_* lag x/y by exactly PIX_LAT clk.
//  frame_start: decoded from registered counters; high in the first cycle after reset.
//  mfram_cnt (5b): increments on the edge closing each frame_start cycle, wraps MFRAM_CNT_MAX-1 -> 0.
//  game_tick = frame_start && mfram_cnt==MFRAM_CNT_MAX-1.
//   Exactly one pulse per MFRAM_CNT_MAX frames.
//  Reset mid-frame: all state clears immediately, without a clock edge.
//   Raster restarts at (0,0); no partial sync pulse is emitted after release.
//  Width rules: 12b counters, unsigned compares, no overflow beyond HFRAME/VFRAME.
// CONFIGURATION
//  HDMI_TPG_EN defined: adds port tpg_on.
//   When tpg_on=1, vid_pix is replaced by 8 vertical bars of HSCREEN/8 px each.
//   Bar colour comes from x delayed PIX_LAT cycles.
//   Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
//   Still 0 when vid_de=0. When tpg_on=0, behaviour is identical to the build without the macro.
//  HDMI_TPG_EN undefined: no tpg_on port, no bar logic; pix_in passes straight through.
// TESTING
//  T1 reset release: x=0, y=0, frame_start=1, vid_de=0, vid_hs=0, vid_vs=0 in first cycle.
//  T2 line: vid_hs high 40 clk, starting 1390+PIX_LAT clk after x==0.
//   vid_de high 1280 clk per visible line; 0 on lines 720..749.
//  T3 wrap: x=1649,y=749 -> next edge x=0,y=0, frame_start=1.
//   vid_vs high exactly lines 725..729.
//  T4 pixel: pix_in=24'h123456 held -> vid_pix=24'h123456 while vid_de=1, 24'h0 in blanking.
//  T5 tick: first game_tick at cycle 29*1237500=35887500 after reset.
//   Next ticks 30 frames (37125000 clk) apart, each 1 clk wide.
//  T6 async reset at x=700,y=300: outputs reach reset values before next clk edge.
//   Clean frame follows release.
//  T7 (HDMI_TPG_EN) tpg_on=1: vid_pix=FFFFFF at aligned x=0, FFFF00 at x=160, 000000 at x=1279.

Source files
------------

// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing
//   Raster timing stage in front of the per-lane TMDS encoders.
//   Free-running 720p60 x/y counters feed the pixel/game generator. Its pixel
//   returns on pix_in PIX_LAT clocks later, so de/hsync/vsync are delayed by
//   the same amount to produce aligned vid_* outputs. Also generates
//   frame_start and the game-speed tick (game_tick).
//   Optional feature: define HDMI_TPG_EN to add the tpg_on input and an
//   8-bar colour test pattern that can replace pix_in.

module hdmi_video_timing #(
    parameter int HFRAME         = 1650,
    parameter int HSCREEN        = 1280,
    parameter int HSYNC_START    = 1390,
    parameter int HSYNC_END      = 1430,
    parameter int VFRAME         = 750,
    parameter int VSCREEN        = 720,
    parameter int VSYNC_START    = 725,
    parameter int VSYNC_END      = 730,
    parameter int PIX_LAT        = 1,
    parameter int MFRAM_CNT_MAX  = 30,
    parameter bit HSYNC_POLARITY = 1'b1,
    parameter bit VSYNC_POLARITY = 1'b1
) (
    input  logic        clk,
    input  logic        arst_n,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic        game_tick,
    input  logic [23:0] pix_in,
    output logic [23:0] vid_pix,
    output logic        vid_de,
    output logic        vid_hs,
    output logic        vid_vs
`ifdef HDMI_TPG_EN
    ,
    input  logic        tpg_on
`endif
);

    localparam logic [11:0] X_LAST   = 12'(HFRAME - 1);
    localparam logic [11:0] Y_LAST   = 12'(VFRAME - 1);
    localparam logic [11:0] X_VIS    = 12'(HSCREEN);
    localparam logic [11:0] Y_VIS    = 12'(VSCREEN);
    localparam logic [11:0] HS_FIRST = 12'(HSYNC_START);
    localparam logic [11:0] HS_STOP  = 12'(HSYNC_END);
    localparam logic [11:0] VS_FIRST = 12'(VSYNC_START);
    localparam logic [11:0] VS_STOP  = 12'(VSYNC_END);
    localparam logic [4:0]  M_LAST   = 5'(MFRAM_CNT_MAX - 1);

    logic               de_raw;
    logic               hs_raw;
    logic               vs_raw;
    logic [PIX_LAT-1:0] de_sr;
    logic [PIX_LAT-1:0] hs_sr;
    logic [PIX_LAT-1:0] vs_sr;
    logic [4:0]         mfram_cnt;

    // Raster counters: x runs every clock, y advances (and wraps) at end of line.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            x <= '0;
            y <= '0;
        end else if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? 12'd0 : y + 12'd1;
        end else begin
            x <= x + 12'd1;
        end
    end

    // Raw timing decode from the registered counters; vsync changes only when
    // y changes, which happens at x==0, so it is inherently line-aligned.
    // NOTE: every combinational output gets a value on every path (here via
    // full expressions) so no latch is inferred.
    always_comb begin
        de_raw = (x < X_VIS) && (y < Y_VIS);
        hs_raw = ((x >= HS_FIRST) && (x < HS_STOP)) ? HSYNC_POLARITY : ~HSYNC_POLARITY;
        vs_raw = ((y >= VS_FIRST) && (y < VS_STOP)) ? VSYNC_POLARITY : ~VSYNC_POLARITY;
    end

    // Delay line matching the generator latency; stage 0 takes the raw decode.
    // NOTE: the delay stages are reset to the idle levels so no partial sync
    // or enable pulse leaks out after a mid-frame reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            de_sr <= '0;
            hs_sr <= {PIX_LAT{~HSYNC_POLARITY}};
            vs_sr <= {PIX_LAT{~VSYNC_POLARITY}};
        end else begin
            de_sr[0] <= de_raw;
            hs_sr[0] <= hs_raw;
            vs_sr[0] <= vs_raw;
            for (int i = 1; i < PIX_LAT; i++) begin
                de_sr[i] <= de_sr[i-1];
                hs_sr[i] <= hs_sr[i-1];
                vs_sr[i] <= vs_sr[i-1];
            end
        end
    end

    assign vid_de = de_sr[PIX_LAT-1];
    assign vid_hs = hs_sr[PIX_LAT-1];
    assign vid_vs = vs_sr[PIX_LAT-1];

    assign frame_start = (x == 12'd0) && (y == 12'd0);

    // Frame counter for the game-speed tick; advances as each frame_start cycle closes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mfram_cnt <= '0;
        end else if (frame_start) begin
            mfram_cnt <= (mfram_cnt == M_LAST) ? 5'd0 : mfram_cnt + 5'd1;
        end
    end

    assign game_tick = frame_start && (mfram_cnt == M_LAST);

`ifdef HDMI_TPG_EN
    localparam int BAR_W = HSCREEN / 8;

    logic [11:0] x_sr [PIX_LAT];
    logic [11:0] x_al;
    logic [11:0] bar_idx;
    logic [23:0] bar_pix;

    // Column delay line so the bar colour lines up with vid_de.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < PIX_LAT; i++) x_sr[i] <= '0;
        end else begin
            x_sr[0] <= x;
            for (int i = 1; i < PIX_LAT; i++) x_sr[i] <= x_sr[i-1];
        end
    end

    assign x_al    = x_sr[PIX_LAT-1];
    assign bar_idx = x_al / 12'(BAR_W);

    // Bar colour lookup, white on the left through black on the right.
    always_comb begin
        bar_pix = 24'h000000;
        case (bar_idx[2:0])
            3'd0: bar_pix = 24'hFFFFFF;
            3'd1: bar_pix = 24'hFFFF00;
            3'd2: bar_pix = 24'h00FFFF;
            3'd3: bar_pix = 24'h00FF00;
            3'd4: bar_pix = 24'hFF00FF;
            3'd5: bar_pix = 24'hFF0000;
            3'd6: bar_pix = 24'h0000FF;
            default: bar_pix = 24'h000000;
        endcase
    end

    assign vid_pix = !vid_de ? 24'h0 : (tpg_on ? bar_pix : pix_in);
`else
    assign vid_pix = vid_de ? pix_in : 24'h0;
`endif

endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing
//   Self-checking bench for hdmi_video_timing on a shrunken raster so whole
//   frames and several game ticks fit in a short run. The reference model
//   derives every output from the cycle number since reset release with
//   plain division/modulo arithmetic.

module tb_hdmi_video_timing;

    localparam int HF    = 40;
    localparam int HSCR  = 24;
    localparam int HSS   = 28;
    localparam int HSE   = 32;
    localparam int VF    = 20;
    localparam int VSCR  = 14;
    localparam int VSS   = 15;
    localparam int VSE   = 17;
    localparam int LAT   = 2;
    localparam int MFM   = 4;
    localparam int FRAME = HF * VF;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [23:0] pix_in = 24'h0;
    logic [11:0] x, y;
    logic        frame_start, game_tick;
    logic [23:0] vid_pix;
    logic        vid_de, vid_hs, vid_vs;
`ifdef HDMI_TPG_EN
    logic        tpg_on = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    int n = 0;

    hdmi_video_timing #(
        .HFRAME(HF), .HSCREEN(HSCR), .HSYNC_START(HSS), .HSYNC_END(HSE),
        .VFRAME(VF), .VSCREEN(VSCR), .VSYNC_START(VSS), .VSYNC_END(VSE),
        .PIX_LAT(LAT), .MFRAM_CNT_MAX(MFM)
    ) dut (
        .clk(clk), .arst_n(arst_n), .x(x), .y(y),
        .frame_start(frame_start), .game_tick(game_tick),
        .pix_in(pix_in), .vid_pix(vid_pix),
        .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs)
`ifdef HDMI_TPG_EN
        , .tpg_on(tpg_on)
`endif
    );

    always #5 clk = ~clk;

    // Expected {x,y,frame_start,game_tick,vid_de,vid_hs,vid_vs,vid_pix} for cycle k.
    function automatic logic [52:0] model(input int k, input logic [23:0] pin);
        logic [11:0] ex, ey;
        logic        fs, gt, de, hs, vs;
        int          mx, my;
        ex = 12'(k % HF);
        ey = 12'((k / HF) % VF);
        fs = (ex == 12'd0) && (ey == 12'd0);
        gt = fs && (((k / FRAME) % MFM) == MFM - 1);
        if (k < LAT) begin
            de = 1'b0; hs = 1'b0; vs = 1'b0;
        end else begin
            mx = (k - LAT) % HF;
            my = ((k - LAT) / HF) % VF;
            de = (mx < HSCR) && (my < VSCR);
            hs = (mx >= HSS) && (mx < HSE);
            vs = (my >= VSS) && (my < VSE);
        end
        return {ex, ey, fs, gt, de, hs, vs, (de ? pin : 24'h0)};
    endfunction

    function automatic logic [52:0] observed();
        return {x, y, frame_start, game_tick, vid_de, vid_hs, vid_vs, vid_pix};
    endfunction

    // Advance one clock, then drive a fresh random pixel away from the edge.
    task automatic step_random();
        @(posedge clk);
        #1;
        n++;
        pix_in = 24'($urandom);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        arst_n = 1'b1;
        n = 0;
        pix_in = 24'($urandom);
        #1;
    endtask

    task automatic test_reset();
        logic [52:0] exp_v;
        arst_n = 1'b0;
        pix_in = 24'hA5A5A5;
        repeat (3) @(posedge clk);
        #2;
        exp_v = model(0, pix_in);
        vectors++;
        if (observed() !== exp_v) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h", observed(), exp_v);
        end
        release_reset();
        for (int i = 0; i < 6; i++) begin
            exp_v = model(n, pix_in);
            vectors++;
            if (observed() !== exp_v) begin
                miscompares++;
                $display("FAIL reset_release n=%0d: got %h want %h", n, observed(), exp_v);
            end
            step_random();
        end
    endtask

    task automatic test_line();
        logic [52:0] exp_v;
        int hs_cnt = 0, de_cnt = 0, hs_rise = -1;
        logic hs_prev = 1'b0;
        while (n % HF != 0) step_random();
        for (int i = 0; i < 2 * HF; i++) begin
            exp_v = model(n, pix_in);
            vectors++;
            if (observed() !== exp_v) begin
                miscompares++;
                $display("FAIL line n=%0d: got %h want %h", n, observed(), exp_v);
            end
            if (i >= HF) begin
                hs_cnt += int'(vid_hs);
                de_cnt += int'(vid_de);
                if (vid_hs && !hs_prev && hs_rise < 0) hs_rise = n % HF;
            end
            hs_prev = vid_hs;
            step_random();
        end
        vectors++;
        if (hs_cnt != HSE - HSS) begin
            miscompares++;
            $display("FAIL hs_width: got %0d want %0d", hs_cnt, HSE - HSS);
        end
        vectors++;
        if (hs_rise != HSS + LAT) begin
            miscompares++;
            $display("FAIL hs_start: got %0d want %0d", hs_rise, HSS + LAT);
        end
        vectors++;
        if (de_cnt != HSCR) begin
            miscompares++;
            $display("FAIL de_width: got %0d want %0d", de_cnt, HSCR);
        end
    endtask

    task automatic test_pixel();
        logic [52:0] exp_v;
        for (int i = 0; i < HF; i++) begin
            pix_in = 24'h123456;
            #1;
            exp_v = model(n, pix_in);
            vectors++;
            if (observed() !== exp_v) begin
                miscompares++;
                $display("FAIL pixel n=%0d: got %h want %h", n, observed(), exp_v);
            end
            @(posedge clk);
            #1;
            n++;
        end
        pix_in = 24'($urandom);
        #1;
    endtask

    task automatic test_frames();
        logic [52:0] exp_v;
        int end_n, ticks = 0, exp_ticks = 0, vs_lines = 0;
        end_n = 2 * MFM * FRAME + 2 * HF;
        for (int k = 0; k * FRAME <= end_n; k++)
            if (k * FRAME >= n && k % MFM == MFM - 1) exp_ticks++;
        while (n <= end_n) begin
            exp_v = model(n, pix_in);
            vectors++;
            if (observed() !== exp_v) begin
                miscompares++;
                $display("FAIL frames n=%0d: got %h want %h", n, observed(), exp_v);
            end
            ticks += int'(game_tick);
            if (n >= FRAME && n < 2 * FRAME && ((n - LAT) % HF == 0) && vid_vs) vs_lines++;
            step_random();
        end
        vectors++;
        if (ticks != exp_ticks) begin
            miscompares++;
            $display("FAIL tick_count: got %0d want %0d", ticks, exp_ticks);
        end
        vectors++;
        if (vs_lines != VSE - VSS) begin
            miscompares++;
            $display("FAIL vs_lines: got %0d want %0d", vs_lines, VSE - VSS);
        end
    endtask

    task automatic test_async_reset();
        logic [52:0] exp_v;
        int target;
        target = (n / FRAME + 1) * FRAME
               + HF * $urandom_range(VSS + 1, VSE - 1) + HSS + LAT + 1;
        while (n < target) step_random();
        @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        exp_v = model(0, pix_in);
        vectors++;
        if (observed() !== exp_v) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", observed(), exp_v);
        end
        repeat (2) @(posedge clk);
        release_reset();
        for (int i = 0; i < FRAME + LAT; i++) begin
            exp_v = model(n, pix_in);
            vectors++;
            if (observed() !== exp_v) begin
                miscompares++;
                $display("FAIL post_reset n=%0d: got %h want %h", n, observed(), exp_v);
            end
            step_random();
        end
    endtask

`ifdef HDMI_TPG_EN
    task automatic test_tpg();
        logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        logic [23:0] exp_pix;
        int mx, my;
        tpg_on = 1'b1;
        while (n % FRAME != 0) step_random();
        for (int i = 0; i < HF + LAT; i++) begin
            mx = (n - LAT) % HF;
            my = ((n - LAT) / HF) % VF;
            exp_pix = ((mx < HSCR) && (my < VSCR)) ? bars[mx / (HSCR / 8)] : 24'h0;
            vectors++;
            if (vid_pix !== exp_pix) begin
                miscompares++;
                $display("FAIL tpg n=%0d: got %h want %h", n, vid_pix, exp_pix);
            end
            step_random();
        end
        tpg_on = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_pixel();
        test_frames();
        test_async_reset();
`ifdef HDMI_TPG_EN
        test_tpg();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
